// File: rtl/spi9252_pkg.sv
// Shared definitions for the AD9252 SPI command path.
//   CMD_W            : width of one SPI command word
//   TEST_MODE,
//   WORK_MODE,
//   TRANSFER_UPDATE  : command words used by requesters and benches
//   state_e          : arbiter FSM state encoding
//   cnt_width()      : counter width able to hold the larger of two limits
package spi9252_pkg;

  localparam int CMD_W = 32;

  localparam logic [CMD_W-1:0] TEST_MODE       = 32'h000D0C0C;
  localparam logic [CMD_W-1:0] WORK_MODE       = 32'h000D0000;
  localparam logic [CMD_W-1:0] TRANSFER_UPDATE = 32'h00FF0101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_GAP
  } state_e;

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/spi_arbiter_9252_rr_arbiter.sv
// Combinational round-robin picker.
//   req_i     : request vector
//   ptr_i     : index of the last granted source; the scan starts one above it
//   gnt_oh_o  : one-hot grant (all zero when nothing requested)
//   gnt_idx_o : index of the granted source
//   valid_o   : at least one request present
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDW-1:0]   ptr_i,
  output logic [N_REQ-1:0] gnt_oh_o,
  output logic [IDW-1:0]   gnt_idx_o,
  output logic             valid_o
);

  always_comb begin
    int           idx;
    logic [IDW-1:0] sel;
    logic         found;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    sel       = '0;
    // Offsets 1..N_REQ visit every source once, ending on the pointer itself,
    // so the last-served source has the lowest priority.
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      sel = IDW'(idx);
      if (!found && req_i[sel]) begin
        found          = 1'b1;
        gnt_idx_o      = sel;
        gnt_oh_o[sel]  = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/spi_arbiter_9252.sv
// Shares one AD9252 SPI write master between N_REQ command sources.
// Round-robin grant, one 32-bit command in flight, minimum idle gap between
// commands, and a timeout if the master never reports busy.
//   clk, reset : clock, synchronous active-high reset
//   req        : per-source request, level-held until ack
//   req_data   : per-source command word, source i at [32i+31:32i]
//   ack        : pulse, command of the source latched and issued
//   done       : pulse, command completed (busy fell)
//   err        : pulse, command timed out (busy never rose)
//   busy_9252  : SPI master busy flag
//   adc_data   : command word to the master, held between commands
//   start      : one-cycle start strobe to the master
//   grant_id   : index of the current/last granted source
//   active     : high from grant until the FSM is back in idle
module spi_arbiter_9252
  import spi9252_pkg::*;
#(
  parameter int N_REQ        = 3,
  parameter int IDW          = 2,
  parameter int BUSY_TIMEOUT = 16,
  parameter int GAP_CYCLES   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [CMD_W*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]         ack,
  output logic [N_REQ-1:0]         done,
  output logic [N_REQ-1:0]         err,
  input  logic                     busy_9252,
  output logic [CMD_W-1:0]         adc_data,
  output logic                     start,
  output logic [IDW-1:0]           grant_id,
  output logic                     active
);

  localparam int CNT_W = cnt_width(BUSY_TIMEOUT, GAP_CYCLES);

  // Per-source view of the flat command bus.
  logic [CMD_W-1:0] req_word [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req_word
    assign req_word[gi] = req_data[gi*CMD_W +: CMD_W];
  end

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic [N_REQ-1:0] oh_q, oh_d;
  logic [CMD_W-1:0] latch_q, latch_d;
  logic [CMD_W-1:0] adc_q, adc_d;
  logic             start_q, start_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [N_REQ-1:0] err_q, err_d;
  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  logic [N_REQ-1:0] arb_oh;
  logic [IDW-1:0]   arb_idx;
  logic             arb_valid;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (arb_oh),
    .gnt_idx_o (arb_idx),
    .valid_o   (arb_valid)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gid_d    = gid_q;
    oh_d     = oh_q;
    latch_d  = latch_q;
    adc_d    = adc_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    start_d  = 1'b0;
    ack_d    = '0;
    done_d   = '0;
    err_d    = '0;

    case (state_q)
      ST_IDLE: begin
        // A master that is already busy (foreign transfer or stuck) blocks grants.
        if (!busy_9252 && arb_valid) begin
          latch_d  = req_word[arb_idx];
          gid_d    = arb_idx;
          ptr_d    = arb_idx;
          oh_d     = arb_oh;
          active_d = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        start_d = 1'b1;
        ack_d   = oh_q;
        adc_d   = latch_q;
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (busy_9252) begin
          state_d = ST_WAIT_DONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(BUSY_TIMEOUT)) begin
            err_d   = oh_q;
            cnt_d   = '0;
            state_d = ST_GAP;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (!busy_9252) begin
          done_d  = oh_q;
          cnt_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        cnt_d = cnt_inc;
        if (cnt_inc == CNT_W'(GAP_CYCLES)) begin
          cnt_d    = '0;
          active_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      // Pointer at the top source so source 0 wins the first arbitration.
      ptr_q    <= IDW'(N_REQ - 1);
      gid_q    <= '0;
      oh_q     <= '0;
      latch_q  <= '0;
      adc_q    <= '0;
      start_q  <= 1'b0;
      ack_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gid_q    <= gid_d;
      oh_q     <= oh_d;
      latch_q  <= latch_d;
      adc_q    <= adc_d;
      start_q  <= start_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      err_q    <= err_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ack      = ack_q;
  assign done     = done_q;
  assign err      = err_q;
  assign adc_data = adc_q;
  assign start    = start_q;
  assign grant_id = gid_q;
  assign active   = active_q;

endmodule
